// File: rtl/output_bcd_sequencer.sv
// Output-path BCD sequencer: captures the bus on OI and converts it to three
// registered BCD digits with an 8-step shift-and-add-3, plus blank flags and busy/valid.
module output_bcd_sequencer #(
  parameter int BLANK_LEADING = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus,
  input  logic       OI,
  output logic [7:0] data_out,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hund,
  output logic       tens_blank,
  output logic       hund_blank,
  output logic       busy,
  output logic       valid
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  localparam logic BLANK_EN = (BLANK_LEADING != 0);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [7:0]  bin_q;
  logic [11:0] bcd_q;
  logic [7:0]  cap_q;
  logic        pend_q;
  logic [7:0]  pend_val_q;
  logic [7:0]  data_out_q;
  logic [3:0]  ones_q, tens_q, hund_q;
  logic        tens_blank_q, hund_blank_q;
  logic        valid_q;

  // One shift-and-add-3 step applied to the current accumulator.
  logic [11:0] bcd_adj;
  logic [19:0] step_d;
  logic [11:0] bcd_d;
  logic [7:0]  bin_d;
  logic        hund_zero_d, tens_zero_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 3; n++) begin
      if (bcd_q[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
    end
    step_d      = {bcd_adj, bin_q} << 1;
    bcd_d       = step_d[19:8];
    bin_d       = step_d[7:0];
    hund_zero_d = (bcd_d[11:8] == 4'd0);
    tens_zero_d = hund_zero_d && (bcd_d[7:4] == 4'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      bin_q        <= 8'd0;
      bcd_q        <= 12'd0;
      cap_q        <= 8'd0;
      pend_q       <= 1'b0;
      pend_val_q   <= 8'd0;
      data_out_q   <= 8'd0;
      ones_q       <= 4'd0;
      tens_q       <= 4'd0;
      hund_q       <= 4'd0;
      tens_blank_q <= BLANK_EN;
      hund_blank_q <= BLANK_EN;
      valid_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (OI) begin
            bin_q   <= bus;
            cap_q   <= bus;
            bcd_q   <= 12'd0;
            cnt_q   <= 3'd0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            ones_q       <= bcd_d[3:0];
            tens_q       <= bcd_d[7:4];
            hund_q       <= bcd_d[11:8];
            data_out_q   <= cap_q;
            hund_blank_q <= BLANK_EN && hund_zero_d;
            tens_blank_q <= BLANK_EN && tens_zero_d;
            valid_q      <= 1'b1;
            // A fresh strobe on the completion edge beats an older pending request.
            if (OI) begin
              bin_q  <= bus;
              cap_q  <= bus;
              bcd_q  <= 12'd0;
              cnt_q  <= 3'd0;
              pend_q <= 1'b0;
            end else if (pend_q) begin
              bin_q  <= pend_val_q;
              cap_q  <= pend_val_q;
              bcd_q  <= 12'd0;
              cnt_q  <= 3'd0;
              pend_q <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else if (OI) begin
            pend_q     <= 1'b1;
            pend_val_q <= bus;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign ones       = ones_q;
  assign tens       = tens_q;
  assign hund       = hund_q;
  assign tens_blank = tens_blank_q;
  assign hund_blank = hund_blank_q;
  assign busy       = (state_q == SHIFT);
  assign valid      = valid_q;

endmodule

// File: tb/tb_output_bcd_sequencer.sv
// Bench for output_bcd_sequencer: directed plan items plus a random run, all
// compared cycle-by-cycle against an arithmetic (div/mod) transaction model.
module tb_output_bcd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus;
  logic       OI;
  logic [7:0] data_out;
  logic [3:0] ones, tens, hund;
  logic       tens_blank, hund_blank, busy, valid;

  output_bcd_sequencer #(.BLANK_LEADING(1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .OI(OI),
    .data_out(data_out), .ones(ones), .tens(tens), .hund(hund),
    .tens_blank(tens_blank), .hund_blank(hund_blank),
    .busy(busy), .valid(valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int vcount = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level model: a conversion is "value + cycles remaining".
  bit m_busy, m_pend, m_valid;
  int m_left, m_cur, m_pv, m_val;

  task automatic m_reset();
    m_busy = 0; m_pend = 0; m_valid = 0;
    m_left = 0; m_cur = 0; m_pv = 0; m_val = 0;
  endtask

  task automatic m_edge(input bit oi, input int b);
    m_valid = 0;
    if (!m_busy) begin
      if (oi) begin m_busy = 1; m_cur = b; m_left = 8; end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_val = m_cur; m_valid = 1;
        if (oi) begin m_cur = b; m_left = 8; m_pend = 0; end
        else if (m_pend) begin m_cur = m_pv; m_left = 8; m_pend = 0; end
        else m_busy = 0;
      end else if (oi) begin
        m_pend = 1; m_pv = b;
      end
    end
  endtask

  function automatic logic [31:0] exp_vec();
    logic [23:0] v;
    v = {8'(m_val), 4'(m_val / 100), 4'((m_val / 10) % 10), 4'(m_val % 10),
         (m_val < 10), (m_val < 100), m_busy, m_valid};
    return 32'(v);
  endfunction

  function automatic logic [31:0] obs_vec();
    return 32'({data_out, hund, tens, ones, tens_blank, hund_blank, busy, valid});
  endfunction

  task automatic cyc(input string tag, input bit oi, input logic [7:0] b);
    OI = oi; bus = b;
    @(posedge clk);
    m_edge(oi, int'(b));
    #1;
    chk(tag, obs_vec(), exp_vec());
    if (valid === 1'b1) vcount++;
    OI = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 8'($urandom_range(0, 255)));
  endtask

  task automatic digits(input string tag, input int h, input int t, input int o,
                        input int tb_, input int hb_);
    chk({tag, "_hund"}, 32'(hund), 32'(h));
    chk({tag, "_tens"}, 32'(tens), 32'(t));
    chk({tag, "_ones"}, 32'(ones), 32'(o));
    chk({tag, "_tblank"}, 32'(tens_blank), 32'(tb_));
    chk({tag, "_hblank"}, 32'(hund_blank), 32'(hb_));
  endtask

  int v0;

  initial begin
    rst = 1'b1; OI = 1'b0; bus = 8'd0;
    m_reset();
    #12;
    chk("reset_vec", obs_vec(), 32'({8'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
    @(negedge clk); rst = 1'b0;

    // 255: busy right after the strobe edge, result after 8 more edges.
    cyc("c255", 1'b1, 8'd255);
    chk("c255_busy_k", 32'(busy), 32'd1);
    idle("c255", 7);
    chk("c255_valid_pre", 32'(valid), 32'd0);
    cyc("c255", 1'b0, 8'd0);
    digits("c255", 2, 5, 5, 0, 0);
    chk("c255_dout", 32'(data_out), 32'd255);
    chk("c255_valid", 32'(valid), 32'd1);
    chk("c255_busy", 32'(busy), 32'd0);
    cyc("c255_after", 1'b0, 8'd0);
    chk("c255_valid_once", 32'(valid), 32'd0);

    cyc("c0", 1'b1, 8'd0);   idle("c0", 8);  digits("c0", 0, 0, 0, 1, 1);
    cyc("c7", 1'b1, 8'd7);   idle("c7", 8);  digits("c7", 0, 0, 7, 1, 1);
    cyc("c42", 1'b1, 8'd42); idle("c42", 8); digits("c42", 0, 4, 2, 0, 1);
    idle("gap", 2);

    // Back-to-back sweep: each next strobe lands on the completion edge.
    v0 = vcount;
    cyc("sweep", 1'b1, 8'd0);
    for (int v = 1; v < 256; v++) begin
      idle("sweep", 7);
      cyc("sweep", 1'b1, 8'(v));
    end
    idle("sweep", 8);
    chk("sweep_valids", 32'(vcount - v0), 32'd256);
    digits("sweep_last", 2, 5, 5, 0, 0);

    // Pending last-wins: 200 overwritten by 99.
    cyc("pend", 1'b1, 8'd123);
    idle("pend", 2);
    cyc("pend", 1'b1, 8'd200);
    idle("pend", 1);
    cyc("pend", 1'b1, 8'd99);
    idle("pend", 3);
    digits("pend123", 1, 2, 3, 0, 0);
    chk("pend123_valid", 32'(valid), 32'd1);
    chk("pend_busy", 32'(busy), 32'd1);
    idle("pend", 8);
    digits("pend99", 0, 9, 9, 0, 1);
    chk("pend99_dout", 32'(data_out), 32'd99);
    idle("pend", 2);

    // Strobe on the completion edge beats a pending 77.
    cyc("prio", 1'b1, 8'd31);
    idle("prio", 1);
    cyc("prio", 1'b1, 8'd77);
    idle("prio", 5);
    cyc("prio", 1'b1, 8'd10);
    idle("prio", 8);
    digits("prio10", 0, 1, 0, 0, 1);
    idle("prio", 10);
    chk("prio_no77", 32'(data_out), 32'd10);

    // Reset mid-conversion.
    cyc("rst", 1'b1, 8'd255); idle("rst", 8);
    cyc("rst", 1'b1, 8'd50);  idle("rst", 4);
    rst = 1'b1;
    #1;
    m_reset();
    chk("rst_async", obs_vec(), exp_vec());
    digits("rst", 0, 0, 0, 1, 1);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_valid", 32'(valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    idle("rst_post", 10);
    chk("rst_post_busy", 32'(busy), 32'd0);

    // Random strobes and bus values.
    for (int i = 0; i < 400; i++)
      cyc("rand", ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)));
    idle("rand_drain", 18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/output_bcd_sequencer.md
Name: output_bcd_sequencer

Overview:
- Sequential controller for the output datapath: captures the bus on OI and converts the 8-bit value to three BCD digits using an 8-step shift-and-add-3 sequence.
- Replaces the combinational divide/modulo feeding the units/tens/hundreds seven_seg decoders.
- Drives those decoders with stable, registered digits, plus leading-zero blank flags and a busy/valid handshake.
- Sits between the bus and the seven_seg instances inside the output module.

Parameters:
- BLANK_LEADING, 1, when 1 the blank flags suppress leading zeros; when 0 both blank flags are held at 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- bus  input  8  data bus value, sampled only when OI=1
- OI  input  1  output-in strobe; request to capture bus and convert
- data_out  output  8  last fully converted binary value
- ones  output  4  BCD units digit (0-9)
- tens  output  4  BCD tens digit (0-9)
- hund  output  4  BCD hundreds digit (0-2)
- tens_blank  output  1  tens digit is a leading zero (value < 10)
- hund_blank  output  1  hundreds digit is a leading zero (value < 100)
- busy  output  1  conversion in progress
- valid  output  1  one-cycle pulse when the outputs update with a new result

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, shift count=0, pending flag=0.
  - data_out, ones, tens and hund = 0.
  - busy=0, valid=0.
  - tens_blank = hund_blank = BLANK_LEADING.
- States: IDLE, SHIFT.
- IDLE, OI=1 at edge k:
  - Load bus into the 8-bit binary shift register and clear the 12-bit BCD accumulator.
  - count=0, state→SHIFT, busy=1 from edge k.
- SHIFT, each edge:
  - Every BCD nibble that is ≥5 gets +3.
  - Then {BCD,bin} shifts left 1, and count increments.
- Completion edge (the 8th SHIFT edge, count==7, i.e. edge k+8):
  - ones/tens/hund take the adjusted and shifted result.
  - data_out takes the captured binary value.
  - Blank flags update and valid=1 for exactly one cycle.
- Latency: OI at edge k → new outputs and valid pulse visible after edge k+8. Throughput is one conversion per 8 cycles.
- Blank rules (BLANK_LEADING=1):
  - hund_blank = (hund==0).
  - tens_blank = (hund==0 && tens==0).
  - ones is never blanked, so value 0 shows a single "0".
- Outputs hold their last result between conversions. The intermediate accumulator is never visible on ones/tens/hund.
- OI while busy (not on the completion edge):
  - Capture bus into the pending register and set pending=1.
  - Repeated OI overwrites pending (last wins).
  - The conversion in flight is unaffected.
- At the completion edge, priority is: OI=1 on that edge > pending > IDLE.
  - OI=1 on that edge: restart immediately with that edge's bus value and clear pending.
  - Else pending=1: restart with the pending value and clear pending.
  - Else state→IDLE.
  - On any restart busy stays 1 with no gap, and valid still pulses for the finished result.
- busy = (state==SHIFT).
- valid is never asserted together with a reset.
- Reset asserted mid-conversion:
  - Aborts immediately with no valid pulse.
  - Outputs return to their reset values and the pending request is discarded.
- Width rules:
  - 8-bit input, maximum 255 → hund ≤ 2.
  - Each nibble stays 0-9 after every step.
  - No overflow path exists.

Test Plan:
- Reset, then OI=1 with bus=8'd255 at edge k → busy=1 from k; after edge k+8: hund=2, tens=5, ones=5, data_out=255, both blanks 0, valid high for one cycle, busy=0.
- OI with bus=8'd0 → after 8 edges: digits 0/0/0, hund_blank=1, tens_blank=1, valid pulse. Repeat with bus=8'd7 → ones=7, both blanks 1. Repeat with bus=8'd42 → tens=4, ones=2, hund_blank=1, tens_blank=0.
- Sweep all 256 values with back-to-back OI issued on each completion edge → digits match value/100, (value/10)%10, value%10; busy never drops; one valid per value.
- Conversion of 123 in flight; OI with bus=200 at edge k+3, then OI with bus=99 at edge k+5 → 123 result at k+8, then 99 at k+16 (200 dropped); busy continuously 1 from k to k+16.
- OI with bus=10 on the completion edge while pending=77 → next result is 10 (tens=1, ones=0, tens_blank=0); 77 is discarded.
- Display 255, start a conversion of 50, assert rst at edge k+4 → outputs immediately 0 with blanks =1 and busy=0, no valid pulse. After release, IDLE with no spurious conversion.
